// File: rtl/alu_seq_muldiv.sv
// Registered EX-stage ALU: single-cycle ADD/SUB/SLT/SLTU/AND/OR plus iterative
// shift-add MUL and restoring DIVU behind a start/busy/done handshake.
module alu_seq_muldiv #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             flush,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             negative,
   output logic             carry,
   output logic             overflow,
   output logic             div_zero
);

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_SLT  = 3'b010;
   localparam logic [2:0] OP_SLTU = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] acc_hi, acc_lo, opb;
   logic             is_div;

   logic accept, iter_op, last_step;

   assign accept    = start && (state != CALC);
   assign iter_op   = op[2] & op[1];
   assign last_step = (state == CALC) && !flush && (cnt == CNT_W'(1));

   // ---------------- single-cycle ALU ----------------
   logic [WIDTH:0]   add_full, sub_full;
   logic             add_ovf, sub_ovf;
   logic [WIDTH-1:0] alu_res;
   logic             alu_carry, alu_ovf;

   assign add_full = {1'b0, a} + {1'b0, b};
   assign sub_full = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
   assign add_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
   assign sub_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);

   // NOTE: every output of a combinational block gets a default first so no
   // path through the case can leave a value unassigned and infer a latch.
   always_comb begin
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res   = add_full[WIDTH-1:0];
            alu_carry = add_full[WIDTH];
            alu_ovf   = add_ovf;
         end
         OP_SUB: begin
            alu_res   = sub_full[WIDTH-1:0];
            alu_carry = sub_full[WIDTH];
            alu_ovf   = sub_ovf;
         end
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, sub_full[WIDTH-1] ^ sub_ovf};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, ~sub_full[WIDTH]};
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         default: alu_res = '0;
      endcase
   end

   // ---------------- iterative step ----------------
   // MUL: {acc_hi,acc_lo} starts as {0, multiplier} and shifts right per step.
   // DIVU: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
   logic [WIDTH:0]   mul_sum, div_shift, div_trial;
   logic [WIDTH-1:0] hi_nxt, lo_nxt;

   assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
   assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
   assign div_trial = div_shift - {1'b0, opb};

   always_comb begin
      if (is_div) begin
         hi_nxt = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
         lo_nxt = {acc_lo[WIDTH-2:0], ~div_trial[WIDTH]};
      end else begin
         hi_nxt = mul_sum[WIDTH:1];
         lo_nxt = {mul_sum[0], acc_lo[WIDTH-1:1]};
      end
   end

   // ---------------- FSM ----------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (accept) state_nxt = iter_op ? CALC : DONE;
            else        state_nxt = IDLE;
         end
         CALC: begin
            if (flush)          state_nxt = IDLE;
            else if (last_step) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == CALC);
      done = (state == DONE);
   end

   // ---------------- datapath and result registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         acc_hi    <= '0;
         acc_lo    <= '0;
         opb       <= '0;
         is_div    <= 1'b0;
         result    <= '0;
         result_hi <= '0;
         zero      <= 1'b0;
         negative  <= 1'b0;
         carry     <= 1'b0;
         overflow  <= 1'b0;
         div_zero  <= 1'b0;
      end else if (accept && iter_op) begin
         cnt    <= CNT_W'(WIDTH);
         acc_hi <= '0;
         acc_lo <= a;
         opb    <= b;
         is_div <= op[0];
      end else if (accept) begin
         result    <= alu_res;
         result_hi <= '0;
         zero      <= (alu_res == '0);
         negative  <= alu_res[WIDTH-1];
         carry     <= alu_carry;
         overflow  <= alu_ovf;
         div_zero  <= 1'b0;
      end else if (state == CALC && !flush) begin
         cnt    <= cnt - CNT_W'(1);
         acc_hi <= hi_nxt;
         acc_lo <= lo_nxt;
         if (last_step) begin
            result    <= lo_nxt;
            result_hi <= hi_nxt;
            zero      <= (lo_nxt == '0);
            negative  <= lo_nxt[WIDTH-1];
            carry     <= 1'b0;
            overflow  <= !is_div && (hi_nxt != '0);
            div_zero  <= is_div && (opb == '0);
         end
      end
   end

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Self-checking bench for alu_seq_muldiv: directed vector table, handshake and
// abort sequences, then random operations against an arithmetic reference model.
module tb_alu_seq_muldiv;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          flush = 1'b0;
   logic [2:0]    op = 3'd0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          busy, done;
   logic [W-1:0]  result, result_hi;
   logic          zero, negative, carry, overflow, div_zero;

   int compared = 0;
   int mismatched = 0;

   alu_seq_muldiv #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .op(op),
      .a(a), .b(b), .busy(busy), .done(done), .result(result),
      .result_hi(result_hi), .zero(zero), .negative(negative),
      .carry(carry), .overflow(overflow), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   // flags packed as {zero, negative, carry, overflow, div_zero}
   typedef struct packed {
      logic [W-1:0] res;
      logic [W-1:0] hi;
      logic [4:0]   flags;
   } exp_t;

   typedef struct {
      string        name;
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      exp_t         exp;
   } vec_t;

   function automatic logic [4:0] flags_now();
      return {zero, negative, carry, overflow, div_zero};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on the operation definitions.
   function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t   e;
      longint sx, sy, sr;
      logic [63:0] p;
      logic   c, v, dz;
      e  = '0;
      c  = 1'b0;
      v  = 1'b0;
      dz = 1'b0;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (o)
         3'd0: begin
            e.res = x + y;
            c  = (64'(x) + 64'(y)) > 64'hFFFF_FFFF;
            sr = sx + sy;
            v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
         end
         3'd1: begin
            e.res = x - y;
            c  = (x >= y);
            sr = sx - sy;
            v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
         end
         3'd2: e.res = (sx < sy) ? 1 : 0;
         3'd3: e.res = (x < y) ? 1 : 0;
         3'd4: e.res = x & y;
         3'd5: e.res = x | y;
         3'd6: begin
            p     = 64'(x) * 64'(y);
            e.res = p[31:0];
            e.hi  = p[63:32];
            v     = (e.hi != 0);
         end
         default: begin
            if (y == 0) begin
               e.res = '1;
               e.hi  = x;
               dz    = 1'b1;
            end else begin
               e.res = x / y;
               e.hi  = x % y;
            end
         end
      endcase
      e.flags = {e.res == 0, e.res[W-1], c, v, dz};
      return e;
   endfunction

   task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
   endtask

   // n counts negedges since the accepting edge (1 = first negedge after it).
   task automatic wait_done(input int n0, output int n, output int bc);
      n  = n0;
      bc = 0;
      while (!done && n < 60) begin
         if (busy) bc++;
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input exp_t e);
      int n, bc, lat;
      issue(o, x, y);
      wait_done(1, n, bc);
      lat = (o == 3'd6 || o == 3'd7) ? W + 1 : 1;
      check({name, " latency"}, n, lat);
      check({name, " busy cycles"}, bc, lat - 1);
      check({name, " result"}, result, e.res);
      check({name, " result_hi"}, result_hi, e.hi);
      check({name, " flags"}, flags_now(), e.flags);
      @(negedge clk);
      check({name, " done one cycle"}, done, 0);
   endtask

   vec_t vecs[15];

   initial begin
      int n, bc, seen;
      logic [2:0]   ro;
      logic [W-1:0] ra, rb;

      vecs[0]  = '{"add 5+7",       3'd0, 32'd5,          32'd7,   '{32'd12,         32'd0,   5'b00000}};
      vecs[1]  = '{"sub 3-10",      3'd1, 32'd3,          32'd10,  '{32'hFFFF_FFF9,  32'd0,   5'b01000}};
      vecs[2]  = '{"sub 10-3",      3'd1, 32'd10,         32'd3,   '{32'd7,          32'd0,   5'b00100}};
      vecs[3]  = '{"slt -3<3",      3'd2, 32'hFFFF_FFFD,  32'd3,   '{32'd1,          32'd0,   5'b00000}};
      vecs[4]  = '{"slt 3<3",       3'd2, 32'd3,          32'd3,   '{32'd0,          32'd0,   5'b10000}};
      vecs[5]  = '{"sltu big<3",    3'd3, 32'hFFFF_FFFD,  32'd3,   '{32'd0,          32'd0,   5'b10000}};
      vecs[6]  = '{"add smax+1",    3'd0, 32'h7FFF_FFFF,  32'd1,   '{32'h8000_0000,  32'd0,   5'b01010}};
      vecs[7]  = '{"add umax+1",    3'd0, 32'hFFFF_FFFF,  32'd1,   '{32'd0,          32'd0,   5'b10100}};
      vecs[8]  = '{"or",            3'd5, 32'd165,        32'd368, '{32'd501,        32'd0,   5'b00000}};
      vecs[9]  = '{"and",           3'd4, 32'd165,        32'd368, '{32'd32,         32'd0,   5'b00000}};
      vecs[10] = '{"mul 165*368",   3'd6, 32'd165,        32'd368, '{32'd60720,      32'd0,   5'b00000}};
      vecs[11] = '{"mul umax*2",    3'd6, 32'hFFFF_FFFF,  32'd2,   '{32'hFFFF_FFFE,  32'd1,   5'b01010}};
      vecs[12] = '{"divu 100/7",    3'd7, 32'd100,        32'd7,   '{32'd14,         32'd2,   5'b00000}};
      vecs[13] = '{"divu 100/0",    3'd7, 32'd100,        32'd0,   '{32'hFFFF_FFFF,  32'd100, 5'b01001}};
      vecs[14] = '{"mul 0*x",       3'd6, 32'd0,          32'd9,   '{32'd0,          32'd0,   5'b10000}};

      // reset state
      #1;
      check("reset busy/done", {busy, done}, 2'b00);
      check("reset result", {result, result_hi}, 64'd0);
      check("reset flags", flags_now(), 5'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

      // back-to-back issue from DONE
      @(negedge clk);
      start = 1'b1; op = 3'd0; a = 32'd1; b = 32'd2;
      @(negedge clk);
      check("b2b first done", done, 1);
      check("b2b first result", result, 32'd3);
      op = 3'd1; a = 32'd5; b = 32'd1;
      @(negedge clk);
      start = 1'b0;
      check("b2b second done", done, 1);
      check("b2b second result", result, 32'd4);
      @(negedge clk);
      check("b2b done drops", done, 0);

      // start ignored mid-CALC, operands changed during CALC
      issue(3'd6, 32'd165, 32'd368);
      repeat (4) @(negedge clk);
      start = 1'b1; op = 3'd0; a = 32'd1; b = 32'd1;
      @(negedge clk);
      start = 1'b0;
      wait_done(6, n, bc);
      check("mid-calc start latency", n, W + 1);
      check("mid-calc start result", result, 32'd60720);
      @(negedge clk);
      check("mid-calc start not queued", {busy, done}, 2'b00);

      // flush ignored outside CALC
      @(negedge clk);
      start = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd2; b = 32'd2;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      wait_done(1, n, bc);
      check("idle flush+start latency", n, 1);
      check("idle flush+start result", result, 32'd4);

      // flush at CALC cycle 10 keeps the prior result
      run_op("pre-flush add", 3'd0, 32'd5, 32'd7, model(3'd0, 32'd5, 32'd7));
      issue(3'd6, 32'h0001_FFFF, 32'h0000_FFFF);
      repeat (9) @(negedge clk);
      flush = 1'b1; start = 1'b1; op = 3'd0;
      @(negedge clk);
      flush = 1'b0; start = 1'b0;
      check("flush -> idle", {busy, done}, 2'b00);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) seen = 1;
      end
      check("flush no done", seen, 0);
      check("flush result kept", {result, result_hi}, {32'd12, 32'd0});
      check("flush flags kept", flags_now(), 5'b0);

      // asynchronous reset mid-DIVU
      issue(3'd7, 32'd100, 32'd7);
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async reset busy/done", {busy, done}, 2'b00);
      check("async reset result", {result, result_hi}, 64'd0);
      check("async reset flags", flags_now(), 5'b0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("post-reset add", 3'd0, 32'd5, 32'd7, model(3'd0, 32'd5, 32'd7));

      // random operations against the reference model
      for (int i = 0; i < 30; i++) begin
         ro = 3'($urandom_range(0, 7));
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = 32'($urandom_range(0, 15));
            1:       rb = 32'($urandom_range(0, 65535));
            default: rb = $urandom;
         endcase
         run_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, model(ro, ra, rb));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/alu_seq_muldiv.md
Name: alu_seq_muldiv

Overview:
- Parametrised, registered successor to the multi-cycle datapath's combinational ALU.
- Adds SLTU, iterative shift-add MUL and restoring DIVU, a start/busy/done handshake, a flush, and registered flags.
- Sits in the EX stage of the multi-cycle processor; the control FSM issues start and stalls on busy.

Parameters:
- WIDTH, 32, operand/result width (≥4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  issue operation; sampled only when busy=0.
- flush  in  1  abort an in-flight MUL/DIVU.
- op  in  3  000 ADD, 001 SUB, 010 SLT, 011 SLTU, 100 AND, 101 OR, 110 MUL, 111 DIVU.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- busy  out  1  iterative operation in progress.
- done  out  1  one-cycle pulse; result/flags valid from this cycle.
- result  out  WIDTH  sum/difference/logic/product low half/quotient.
- result_hi  out  WIDTH  MUL: product high half; DIVU: remainder; otherwise 0.
- zero  out  1  result==0.
- negative  out  1  result[WIDTH-1].
- carry  out  1  ADD carry-out; SUB: 1 = no borrow (a ≥ b unsigned); otherwise 0.
- overflow  out  1  ADD/SUB signed overflow; MUL: result_hi≠0; otherwise 0.
- div_zero  out  1  DIVU with b==0; otherwise 0.

Behaviour:
- Reset: the asynchronous assertion of rst_n=0 does the following:
  - state=IDLE.
  - All outputs and internal registers are cleared to 0.
  - Any in-flight operation is lost; no done is produced.
- States: IDLE, CALC, DONE.
  - busy = (state==CALC).
  - done = (state==DONE).
- Start acceptance: start is accepted in IDLE or DONE, so back-to-back issue is allowed.
  - In CALC, start is ignored and does not queue.
  - a, b and op are latched at acceptance; later input changes have no effect on that operation.
- Single-cycle ops (ADD, SUB, SLT, SLTU, AND, OR):
  - Result and flags are registered at the accepting edge; state goes to DONE.
  - done rises in the cycle after start.
- SLT/SLTU: result = {WIDTH-1 zeros, lt}.
  - lt is the signed or unsigned comparison respectively.
  - carry and overflow are 0.
- SUB is computed as a + ~b + 1; carry is the true adder carry-out.
- MUL (unsigned):
  - Accepting edge: CALC, counter=WIDTH, product accumulator cleared.
  - Each CALC cycle performs one shift-add step and decrements the counter.
  - When the counter reaches 0, the state goes to DONE.
  - done is asserted exactly WIDTH+1 cycles after the start cycle; busy is high for WIDTH cycles.
- DIVU (restoring): same timing as MUL, one quotient bit per cycle.
  - b==0 follows the natural restoring result: quotient all-ones, remainder=a, div_zero=1, same latency.
- Flags:
  - zero and negative always reflect the registered result.
  - All flags update only on the edge that enters DONE.
  - Flags and results hold their values until the next accepted start.
- done: a one-cycle pulse. If no new start arrives in DONE, the state returns to IDLE with outputs held.
- flush:
  - In CALC: the state goes to IDLE at the next edge, done is not pulsed, and result/flags keep their prior values.
  - In IDLE/DONE: flush is ignored.
  - flush and start in the same cycle: flush has priority only in CALC; otherwise start is accepted.
- Counter wrap is not possible: the counter only counts down from WIDTH and stops at 0.
- No combinational path from inputs to outputs.

Test Plan:
- Single-cycle ADD and SUB (WIDTH=32):
  - ADD a=5, b=7: result=12, all flags 0, done high in the cycle after start, busy never set.
  - SUB a=3, b=10: result=0xFFFFFFF9, negative=1, carry=0, overflow=0.
- Compare ops:
  - SLT a=-3, b=3 → 1.
  - SLT a=3, b=3 → 0 with zero=1.
  - SLTU a=0xFFFFFFFD, b=3 → 0.
  - Back-to-back starts in consecutive cycles produce consecutive done pulses.
- Adder boundaries:
  - ADD 0x7FFFFFFF+1 → 0x80000000, overflow=1, negative=1.
  - ADD 0xFFFFFFFF+1 → 0, zero=1, carry=1, overflow=0.
  - OR 165|368 → 501; AND 165&368 → 32.
- MUL timing and overflow:
  - MUL 165×368: result=60720 (0xED30), result_hi=0; busy high 32 cycles; done exactly 33 cycles after start.
  - start pulsed mid-CALC is ignored.
  - MUL 0xFFFFFFFF×2: result=0xFFFFFFFE, result_hi=1, overflow=1.
- DIVU:
  - 100/7: result=14, result_hi=2, div_zero=0.
  - 100/0: result=0xFFFFFFFF, result_hi=100, div_zero=1.
  - Operands changed during CALC do not alter the result.
- Abort paths:
  - flush at CALC cycle 10 → IDLE next edge, no done, prior result retained.
  - rst_n low mid-DIVU → all outputs 0 immediately (asynchronous).
  - After release, a new ADD completes normally.
